// File: rtl/ml_accel_pkg.sv
// Shared datapath types, widths and saturation helper for the ML accelerator stages.
package ml_accel_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_WRITE,
        S_DONE
    } conv_state_t;

    localparam acc_t SAT_MAX = acc_t'(127);
    localparam acc_t SAT_MIN = acc_t'(-128);

    function automatic data_t sat8(input acc_t y);
        if (y > SAT_MAX)
            return data_t'(SAT_MAX[DATA_W-1:0]);
        else if (y < SAT_MIN)
            return data_t'(SAT_MIN[DATA_W-1:0]);
        else
            return data_t'(y[DATA_W-1:0]);
    endfunction

endpackage

// File: rtl/conv_layer_mac.sv
// Registered signed multiply-accumulate used by conv_layer; clr has priority over en.
import ml_accel_pkg::*;

module mac_unit (
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  en,
    input  data_t a,
    input  data_t b,
    output acc_t  acc
);

    logic signed [2*DATA_W-1:0] prod;
    acc_t                       prod_ext;

    always_comb begin
        prod     = a * b;
        prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end

    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= '0;
        else if (en)
            acc <= acc + prod_ext;
    end

endmodule

// File: rtl/conv_layer.sv
// 3x3 single-channel convolution, one MAC per cycle, shift/bias/saturate per pixel.
// Optional build macro CONV_RELU_EN clamps negative outputs to zero.
import ml_accel_pkg::*;

module conv_layer #(
    parameter int IN_DIM  = 8,
    parameter int K       = 3,
    parameter int OUT_DIM = IN_DIM - K + 1,
    parameter int SHIFT   = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  data_t input_fm  [0:IN_DIM*IN_DIM-1],
    input  data_t kernel    [0:K*K-1],
    input  data_t bias,
    output logic  busy,
    output logic  done,
    output data_t output_fm [0:OUT_DIM*OUT_DIM-1]
);

    localparam int TAP_W = $clog2(K*K);
    localparam int RC_W  = $clog2(OUT_DIM);
    localparam int IDX_W = $clog2(IN_DIM*IN_DIM);
    localparam int OUT_W = $clog2(OUT_DIM*OUT_DIM);

    conv_state_t state, next_state;

    data_t            in_q [0:IN_DIM*IN_DIM-1];
    data_t            k_q  [0:K*K-1];
    data_t            bias_q;
    logic [TAP_W-1:0] tap;
    logic [RC_W-1:0]  row, col;

    logic [IDX_W-1:0] win_idx;
    logic [OUT_W-1:0] out_idx;
    logic             take_start, last_tap, last_pix;
    logic             mac_clr, mac_en;
    acc_t             acc, y;
    data_t            px;

    always_comb begin
        win_idx = IDX_W'((32'(row) + 32'(tap) / K) * IN_DIM + 32'(col) + 32'(tap) % K);
        out_idx = OUT_W'(32'(row) * OUT_DIM + 32'(col));
        take_start = start && (state == S_IDLE || state == S_DONE);
        last_tap = (tap == TAP_W'(K*K-1));
        last_pix = (row == RC_W'(OUT_DIM-1)) && (col == RC_W'(OUT_DIM-1));
        mac_clr  = take_start || (state == S_WRITE);
        mac_en   = (state == S_MAC);
    end

    mac_unit u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (in_q[win_idx]),
        .b   (k_q[tap]),
        .acc (acc)
    );

    always_comb begin
        y  = (acc >>> SHIFT) + acc_t'(bias_q);
        px = sat8(y);
`ifdef CONV_RELU_EN
        if (px < 0)
            px = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: if (start) next_state = S_MAC;
            S_MAC:          if (last_tap) next_state = S_WRITE;
            S_WRITE:        next_state = last_pix ? S_DONE : S_MAC;
            default:        next_state = S_IDLE;
        endcase
    end

    assign busy = (state == S_MAC) || (state == S_WRITE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < IN_DIM*IN_DIM; i++) in_q[i] <= '0;
            for (int unsigned i = 0; i < K*K; i++) k_q[i] <= '0;
            for (int unsigned i = 0; i < OUT_DIM*OUT_DIM; i++) output_fm[i] <= '0;
            bias_q <= '0;
            tap    <= '0;
            row    <= '0;
            col    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        in_q   <= input_fm;
                        k_q    <= kernel;
                        bias_q <= bias;
                        tap    <= '0;
                        row    <= '0;
                        col    <= '0;
                    end
                end
                S_MAC: tap <= tap + 1'b1;
                S_WRITE: begin
                    output_fm[out_idx] <= px;
                    tap <= '0;
                    if (col == RC_W'(OUT_DIM-1)) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer.sv
// Scoreboard bench for conv_layer: reference frames queued at start, checked when done rises.
module tb_conv_layer;

    localparam int SHIFT = 4;

    logic              clk = 1'b0;
    logic              rst, start;
    logic signed [7:0] in_fm  [0:63];
    logic signed [7:0] kern   [0:8];
    logic signed [7:0] bias;
    logic              busy, done;
    logic signed [7:0] out_fm [0:35];

    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    int unsigned  exp_due [$];
    logic [287:0] exp_px  [$];

    conv_layer #(.IN_DIM(8), .K(3), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .input_fm  (in_fm),
        .kernel    (kern),
        .bias      (bias),
        .busy      (busy),
        .done      (done),
        .output_fm (out_fm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Direct convolution of the current inputs from the arithmetic definition.
    function automatic logic [287:0] ref_frame();
        logic [287:0] res;
        int acc, y;
        res = '0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                acc = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += int'(in_fm[(r+i)*8 + c + j]) * int'(kern[i*3 + j]);
                y = (acc >>> SHIFT) + int'(bias);
                if (y > 127) y = 127;
                if (y < -128) y = -128;
`ifdef CONV_RELU_EN
                if (y < 0) y = 0;
`endif
                res[(r*6 + c)*8 +: 8] = 8'(y);
            end
        end
        return res;
    endfunction

    initial begin
        logic         prev;
        int unsigned  due;
        logic [287:0] px;
        logic signed [7:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !prev) begin
                if (exp_due.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected no frame pending", cyc);
                end else begin
                    due = exp_due.pop_front();
                    px  = exp_px.pop_front();
                    check("done_latency", int'(cyc), int'(due));
                    for (int i = 0; i < 36; i++) begin
                        e = px[i*8 +: 8];
                        check($sformatf("pixel[%0d]", i), int'(out_fm[i]), int'(e));
                    end
                end
            end
            prev = done;
        end
    end

    task automatic fill(input int in_val, input int k_val, input int b_val);
        for (int i = 0; i < 64; i++) in_fm[i] = 8'(in_val);
        for (int i = 0; i < 9; i++) kern[i] = 8'(k_val);
        bias = 8'(b_val);
    endtask

    task automatic fill_random(input int k_lo, input int k_hi);
        for (int i = 0; i < 64; i++) in_fm[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 9; i++) kern[i] = 8'(int'($urandom_range(0, k_hi - k_lo)) + k_lo);
        bias = 8'($urandom_range(0, 255));
    endtask

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        exp_due.push_back(cyc + 361);
        exp_px.push_back(ref_frame());
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("done_after_start", int'(done), 0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 450) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 after %0d cycles expected done=1", n);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        fill(0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        for (int i = 0; i < 36; i++) check($sformatf("reset_out[%0d]", i), int'(out_fm[i]), 0);
        rst = 1'b0;

        // Uniform maps: in-range, positive saturation, negative.
        fill(1, 16, 0);
        start_frame();
        wait_done();
        fill(127, 127, 0);
        start_frame();
        wait_done();
        fill(1, -16, 0);
        start_frame();
        wait_done();

        // Centre-tap identity, then disturb inputs and pulse start mid-frame.
        fill(0, 0, 0);
        for (int i = 0; i < 64; i++) in_fm[i] = 8'(i - 32);
        kern[4] = 8'sd16;
        start_frame();
        repeat (48) @(negedge clk);
        fill_random(-128, 127);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_ignored_start", int'(busy), 1);
        wait_done();

        // Start while in DONE.
        fill_random(-8, 7);
        start_frame();
        wait_done();

        // Reset mid-frame abandons it; restart afterwards.
        fill_random(-8, 7);
        start_frame();
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(exp_due.pop_back());
        void'(exp_px.pop_back());
        check("midreset_done", int'(done), 0);
        check("midreset_busy", int'(busy), 0);
        for (int i = 0; i < 36; i++) check($sformatf("midreset_out[%0d]", i), int'(out_fm[i]), 0);
        fill_random(-8, 7);
        start_frame();
        wait_done();

        for (int f = 0; f < 5; f++) begin
            if (f % 2 == 0) fill_random(-8, 7);
            else fill_random(-128, 127);
            start_frame();
            wait_done();
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drain", exp_due.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_layer.md
# conv_layer

Single-channel 3x3 convolution stage that feeds `pool_layer`. It takes an 8x8 signed 8-bit input map, a 3x3 signed kernel and a bias, and produces the 6x6 signed 8-bit feature map that `pool_layer` consumes on its `input_fm[0:35]` port. It uses one multiply-accumulate per cycle and rescales and saturates each result. It raises `done` when the full map is valid.

## Interface
- `IN_DIM`, 8: input map width/height (square).
- `K`, 3: kernel width/height.
- `OUT_DIM`, `IN_DIM-K+1` = 6: output map width/height.
- `SHIFT`, 4: arithmetic right shift applied to the accumulator before bias add.
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a frame; sampled only in IDLE.
- `input_fm[0:63]` in 8 each, signed: row-major input map.
- `kernel[0:8]` in 8 each, signed: row-major 3x3 weights.
- `bias` in 8, signed: added after the shift.
- `busy` out 1: high in MAC and WRITE.
- `done` out 1: level; high in DONE.
- `output_fm[0:35]` out 8 each, signed: row-major 6x6 result, direct feed to `pool_layer.input_fm`.

## Operation
- FSM states: IDLE, MAC, WRITE, DONE.
- **IDLE**, `start`=1:
  - Snapshot `input_fm`, `kernel` and `bias` into internal registers. Inputs may change afterwards.
  - Clear acc, tap, row and col.
  - Clear `done`.
  - Go to MAC.
- **MAC**:
  - acc += win[tap] * kernel[tap], where win[tap] = in[(row + tap/3)*IN_DIM + col + tap%3].
  - tap++.
  - After tap 8, go to WRITE.
- **WRITE**:
  - y = (acc >>> SHIFT) + bias, sign-extended.
  - Saturate y to [-128, 127].
  - Write y to `output_fm[row*OUT_DIM+col]`.
  - Clear acc and tap.
  - Advance col. On wrap, col=0 and row++.
  - If pixel 35 was just written: set `done`=1 and go to DONE. Otherwise go to MAC.
- **DONE**:
  - Hold `done` and `output_fm`.
  - `start` returns to the IDLE action, i.e. snapshot and go to MAC in the same edge; `done` clears there.
- Widths:
  - Product is 16-bit signed.
  - acc is 20-bit signed (ACC_W), enough for 9 products with no overflow.
  - Shift is arithmetic.
  - Bias add is done at ACC_W.
  - Saturation is a single compare pair.
- `start` in MAC or WRITE is ignored; the frame is not restarted.
- Entries of `output_fm` not yet written in the current frame keep their previous values. Consumers use only `done`.

## Timing
- Reset values:
  - state=IDLE, `done`=0, `busy`=0.
  - All `output_fm`=0; acc, tap, row, col = 0.
  - Snapshot registers = 0.
- `rst` mid-frame: at the next edge, all of the above apply and the frame is abandoned. `rst` has priority over `start` on the same edge.
- `start` sampled at edge N:
  - MAC occupies edges N+1..N+9.
  - Pixel p is written at edge N+10(p+1).
  - Pixel 35 and `done`=1 land at edge N+360.
- Per-frame latency: 360 cycles after the start edge. Throughput: 10 cycles per pixel.
- `busy` is high from after edge N until edge N+360.
- There is no backpressure. `pool_layer.start` may be driven from `done` directly.

## Configuration
- `CONV_RELU_EN`:
  - Defined: after saturation, negative y is forced to 0, so the output range is [0, 127].
  - Undefined: signed output over the full [-128, 127] range.
  - Cycle timing is identical in both builds.

## Structure
- Shared package `ml_accel_pkg`:
  - `DATA_W`=8 and `ACC_W`=20.
  - Signed data and acc typedefs.
  - `sat8()` saturation function.
  - These are reused by `pool_layer` and later stages.
- Sub-module `mac_unit`:
  - Ports: clk, rst, clr, en, signed a/b 8-bit, 20-bit acc output.
  - Registered accumulate: with en, acc <= acc + a*b.
  - clr has priority over en.
- `conv_layer` holds the FSM, snapshot, window indexing and the WRITE datapath.

## Test plan
- Input all 1, kernel all 1, bias 0, SHIFT 0 -> all 36 outputs = 9; `done` rises exactly 360 cycles after the start edge.
- Input all 127, kernel all 127, SHIFT 4 -> all outputs = 127, saturated (acc 145161 >>> 4 = 9072).
- Input all 1, kernel all -1, bias 0, SHIFT 0 -> all outputs = -9 without `CONV_RELU_EN`; all 0 with it.
- Kernel center = 16, others 0, SHIFT 4, bias 0, input[i] = i-32 -> `output_fm[r*6+c]` = input[(r+1)*8 + c+1]. Then change `input_fm` mid-frame -> result unchanged (snapshot).
- Assert `rst` 100 cycles after start -> next cycle `done`=0, `busy`=0, all outputs 0. Restart -> correct map and latency.
- Pulse `start` again at cycle 50 of a frame -> ignored; `done` still at +360. `start` in DONE -> `done` drops on that edge, new frame completes.
